glb_block_framer: RTL and testbench

Length-prefix framer that sits directly upstream of the GLB read sink in the memory-core test path. Accumulates one block of 16-bit words from a memory-core output stream, then emits that block on a 17-bit ready/valid stream as a size header word followed by the payload words. This is the framing the GLB read side consumes. Single-buffered: input is stalled while a framed block drains.

---
 rtl/glb_block_framer.sv | 174 +++++++++++++++++
 tb/tb_glb_block_framer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glb_block_framer.sv
// -----------------------------------------------------------------------------
// glb_block_framer
//
// Length-prefix framer placed upstream of the GLB read sink. Collects one
// block of DATA_WIDTH-bit words from a memory-core output stream into a
// single buffer. It then sends the block downstream as a size header word
// followed by the payload words. While a framed block is pending or draining,
// input is stalled.
//
// Ports
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset (priority over flush)
//   flush        synchronous clear of framing state; keeps blocks_sent/overflow
//   in_data      payload word
//   in_valid     in_data valid
//   in_last      in_data is the final word of the block
//   in_ready     block accepts input (FILL state, not in reset)
//   out_data     [DATA_WIDTH] = last-payload flag, [DATA_WIDTH-1:0] = header/payload
//   out_valid    out_data valid
//   out_ready    downstream accepts
//   busy         a framed block is pending or draining
//   overflow     sticky: a block was force-closed at DEPTH words
//   blocks_sent  count of fully drained blocks, wraps at 2^16
// -----------------------------------------------------------------------------
module glb_block_framer #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 2048,
   parameter int AW         = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   input  logic                  in_last,
   output logic                  in_ready,
   output logic [DATA_WIDTH:0]   out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  overflow,
   output logic [15:0]           blocks_sent
);

   // Buffer index width; DEPTH is a power of two.
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      S_FILL,
      S_HDR,
      S_DRAIN
   } state_t;

   state_t                 state, state_d;
   logic [AW-1:0]          wcnt, wcnt_d;
   logic [AW-1:0]          rcnt, rcnt_d;
   logic [AW-1:0]          wcnt_inc, rcnt_inc;
   logic                   out_valid_d;
   logic [DATA_WIDTH:0]    out_data_d;
   logic                   busy_d;
   logic                   overflow_d;
   logic [15:0]            blocks_sent_d;
   logic                   in_fire, out_fire;

   logic [DATA_WIDTH-1:0]  mem [DEPTH];

   // Decoded from the state register only, so out_ready has no path to it.
   assign in_ready = (state == S_FILL) && !rst;
   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   // NOTE: the buffer has no reset; its contents are only read after being
   // written in the current block, and a reset would block RAM inference.
   always_ff @(posedge clk) begin
      if (in_fire) begin
         mem[wcnt[IW-1:0]] <= in_data;
      end
   end

   // Next-state and next-output logic. The buffer read is registered into
   // out_data on the transfer that advances to the next word. This covers
   // the buf[0] read on the header transfer and the buf[rcnt+1] read on each
   // payload transfer, so payload leaves at one word per cycle.
   // NOTE: every variable gets a default first so no latch is inferred.
   always_comb begin
      state_d       = state;
      wcnt_d        = wcnt;
      rcnt_d        = rcnt;
      out_valid_d   = out_valid;
      out_data_d    = out_data;
      overflow_d    = overflow;
      blocks_sent_d = blocks_sent;
      wcnt_inc      = wcnt + 1'b1;
      rcnt_inc      = rcnt + 1'b1;

      case (state)
         S_FILL: begin
            if (in_fire) begin
               wcnt_d = wcnt_inc;
               // A block closes on in_last, or is forced closed when the buffer fills.
               if (in_last || (wcnt_inc == AW'(DEPTH))) begin
                  state_d     = S_HDR;
                  out_valid_d = 1'b1;
                  out_data_d  = {1'b0, DATA_WIDTH'(wcnt_inc)};
                  if (wcnt_inc == AW'(DEPTH)) begin
                     overflow_d = 1'b1;
                  end
               end
            end
         end

         S_HDR: begin
            if (out_fire) begin
               state_d    = S_DRAIN;
               rcnt_d     = '0;
               out_data_d = {(wcnt == AW'(1)), mem[0]};
            end
         end

         S_DRAIN: begin
            if (out_fire) begin
               if (rcnt == wcnt - 1'b1) begin
                  state_d       = S_FILL;
                  wcnt_d        = '0;
                  rcnt_d        = '0;
                  out_valid_d   = 1'b0;
                  blocks_sent_d = blocks_sent + 16'd1;
               end else begin
                  rcnt_d     = rcnt_inc;
                  out_data_d = {(rcnt_inc == wcnt - 1'b1), mem[rcnt_inc[IW-1:0]]};
               end
            end
         end

         default: begin
            state_d = S_FILL;
         end
      endcase

      // flush discards any partial or pending block but keeps the statistics.
      if (flush) begin
         state_d     = S_FILL;
         wcnt_d      = '0;
         rcnt_d      = '0;
         out_valid_d = 1'b0;
      end

      busy_d = (state_d != S_FILL);
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_FILL;
         wcnt        <= '0;
         rcnt        <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         busy        <= 1'b0;
         overflow    <= 1'b0;
         blocks_sent <= '0;
      end else begin
         state       <= state_d;
         wcnt        <= wcnt_d;
         rcnt        <= rcnt_d;
         out_valid   <= out_valid_d;
         out_data    <= out_data_d;
         busy        <= busy_d;
         overflow    <= overflow_d;
         blocks_sent <= blocks_sent_d;
      end
   end

endmodule

// File: tb/tb_glb_block_framer.sv
// -----------------------------------------------------------------------------
// tb_glb_block_framer
//
// Self-checking bench for glb_block_framer (DEPTH = 8). The reference model is
// a queue of the words the sink must see: a header equal to the block size,
// then the payload words with the flag bit set on the final one. Words that
// leave the DUT are collected by a monitor and compared against that queue.
// -----------------------------------------------------------------------------
module tb_glb_block_framer;

   localparam int DW    = 16;
   localparam int DEPTH = 8;
   localparam int AW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst;
   logic          flush;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_last;
   logic          in_ready;
   logic [DW:0]   out_data;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic          overflow;
   logic [15:0]   blocks_sent;

   int tests = 0;
   int fails = 0;

   logic [DW:0] got[$];
   logic [DW:0] exp_q[$];
   bit          rand_ready = 1'b0;
   bit          hold       = 1'b0;
   logic [DW:0] hold_data  = '0;

   glb_block_framer #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_last     (in_last),
      .in_ready    (in_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .busy        (busy),
      .overflow    (overflow),
      .blocks_sent (blocks_sent)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Random sink readiness when enabled; otherwise tasks drive out_ready.
   always begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   end

   // Sink monitor: pre-edge values describe the transfer taken at this edge.
   always @(posedge clk) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) got.push_back(out_data);
      hold      = (out_valid === 1'b1) && (out_ready === 1'b0) && !flush && !rst;
      hold_data = out_data;
   end

   // A stalled word must stay put, and input is taken exactly when no block is pending.
   always @(negedge clk) begin
      if (hold) begin
         tests++;
         if (out_valid !== 1'b1 || out_data !== hold_data) begin
            fails++;
            $display("FAIL hold_stable: valid=%b data=%h, need valid=1 data=%h",
                     out_valid, out_data, hold_data);
         end
      end
      if (!rst) begin
         tests++;
         if (in_ready !== !busy) begin
            fails++;
            $display("FAIL ready_vs_busy: in_ready=%b busy=%b", in_ready, busy);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   // Offer one word and hold it until the DUT takes it (bounded).
   task automatic send_word(input logic [DW-1:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int n = 0; ; n++) begin
         if (in_ready === 1'b1) begin
            step();
            break;
         end
         step();
         if (n > 2000) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: word %h never accepted", d);
            break;
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Send a closed block of len random words and record the expected sink view.
   task automatic send_block(input int len);
      logic [DW-1:0] w;
      exp_q.push_back({1'b0, 16'(len)});
      for (int i = 0; i < len; i++) begin
         w = 16'($urandom);
         exp_q.push_back({(i == len - 1), w});
         send_word(w, (i == len - 1));
      end
   endtask

   task automatic wait_got(input int n);
      for (int c = 0; got.size() < n; c++) begin
         step();
         if (c > 3000) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d words, expected %0d", got.size(), n);
            break;
         end
      end
   endtask

   task automatic compare_q(input string name);
      tests++;
      if (got.size() != exp_q.size()) begin
         fails++;
         $display("FAIL %s_count: got %0d words, expected %0d", name, got.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
         tests++;
         if (got[i] !== exp_q[i]) begin
            fails++;
            $display("FAIL %s[%0d]: got %h, expected %h", name, i, got[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) step();
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_blocks_sent", 32'(blocks_sent), 0);
      rst = 1'b0;
      #1;
      chk("rst_release_in_ready", 32'(in_ready), 1);
   endtask

   task automatic test_basic();
      logic [DW:0] exp_w [5];
      exp_w[0] = 17'h00004;
      exp_w[1] = 17'h01111;
      exp_w[2] = 17'h02222;
      exp_w[3] = 17'h03333;
      exp_w[4] = 17'h14444;
      step();
      out_ready = 1'b1;
      send_word(16'h1111, 1'b0);
      send_word(16'h2222, 1'b0);
      send_word(16'h3333, 1'b0);
      send_word(16'h4444, 1'b1);
      // Header must be visible in the cycle right after in_last is taken.
      chk("basic_hdr_in_ready", 32'(in_ready), 0);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("basic_valid%0d", k), 32'(out_valid), 1);
         chk($sformatf("basic_word%0d", k), 32'(out_data), 32'(exp_w[k]));
         step();
      end
      chk("basic_in_ready_after", 32'(in_ready), 1);
      chk("basic_valid_after", 32'(out_valid), 0);
      chk("basic_blocks_sent", 32'(blocks_sent), 1);
   endtask

   task automatic test_back_to_back();
      logic [15:0] bs0;
      got.delete();
      exp_q.delete();
      bs0 = blocks_sent;
      rand_ready = 1'b1;
      send_block(3);
      exp_q.push_back(17'h00001);
      exp_q.push_back(17'h1BEEF);
      send_word(16'hBEEF, 1'b1);
      // The second block can only be taken once the first has fully left.
      chk("b2b_stalled_until_drained", 32'(got.size() >= 4), 1);
      wait_got(6);
      rand_ready = 1'b0;
      out_ready  = 1'b0;
      compare_q("b2b");
      chk("b2b_blocks_sent", 32'(blocks_sent), 32'(bs0 + 16'd2));
   endtask

   task automatic test_random_blocks();
      logic [15:0] bs0;
      got.delete();
      exp_q.delete();
      bs0 = blocks_sent;
      rand_ready = 1'b1;
      for (int b = 0; b < 6; b++) send_block($urandom_range(1, DEPTH - 1));
      wait_got(exp_q.size());
      rand_ready = 1'b0;
      out_ready  = 1'b0;
      compare_q("rand");
      chk("rand_blocks_sent", 32'(blocks_sent), 32'(bs0 + 16'd6));
      chk("rand_no_overflow", 32'(overflow), 0);
   endtask

   task automatic test_overflow();
      logic [DW-1:0] w;
      got.delete();
      exp_q.delete();
      out_ready = 1'b1;
      exp_q.push_back({1'b0, 16'(DEPTH)});
      for (int i = 0; i < 10; i++) begin
         w = 16'($urandom);
         if (i < DEPTH) exp_q.push_back({(i == DEPTH - 1), w});
         send_word(w, 1'b0);
         // Word 9 is taken only after the forced block has drained completely.
         if (i == DEPTH) chk("ovf_word9_after_drain", 32'(got.size()), 32'(DEPTH + 1));
      end
      repeat (3) step();
      compare_q("ovf");
      chk("ovf_flag", 32'(overflow), 1);
      chk("ovf_partial_not_sent", 32'(out_valid), 0);
      // Discard the partial 2-word block left in the buffer.
      flush = 1'b1;
      step();
      flush = 1'b0;
      repeat (3) step();
      chk("ovf_after_flush_count", 32'(got.size()), 32'(DEPTH + 1));
      chk("ovf_sticky", 32'(overflow), 1);
      out_ready = 1'b0;
   endtask

   task automatic test_backpressure();
      got.delete();
      exp_q.delete();
      out_ready = 1'b0;
      send_block(2);
      for (int c = 0; c < 20; c++) begin
         chk("bp_valid", 32'(out_valid), 1);
         chk("bp_data", 32'(out_data), 32'h00002);
         chk("bp_in_ready", 32'(in_ready), 0);
         step();
      end
      rand_ready = 1'b1;
      wait_got(3);
      rand_ready = 1'b0;
      out_ready  = 1'b0;
      compare_q("bp");
   endtask

   task automatic test_flush();
      logic [15:0] bs0;
      got.delete();
      exp_q.delete();
      bs0 = blocks_sent;
      out_ready = 1'b0;
      send_block(5);
      chk("flush_in_hdr", 32'(out_valid), 1);
      out_ready = 1'b1;
      repeat (3) step();
      out_ready = 1'b0;
      flush     = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_out_valid", 32'(out_valid), 0);
      chk("flush_in_ready", 32'(in_ready), 1);
      chk("flush_busy", 32'(busy), 0);
      chk("flush_blocks_sent", 32'(blocks_sent), 32'(bs0));
      chk("flush_overflow_kept", 32'(overflow), 1);
      // Only header and first two payload words were delivered.
      exp_q = exp_q[0:2];
      repeat (5) step();
      compare_q("flush_partial");
      got.delete();
      exp_q.delete();
      rand_ready = 1'b1;
      send_block(2);
      wait_got(3);
      rand_ready = 1'b0;
      out_ready  = 1'b0;
      compare_q("flush_next");
      chk("flush_next_hdr", 32'(got.size() > 0 ? got[0] : 17'h1FFFF), 32'h00002);
      chk("flush_next_blocks_sent", 32'(blocks_sent), 32'(bs0 + 16'd1));
   endtask

   task automatic test_rst_in_drain();
      got.delete();
      exp_q.delete();
      out_ready = 1'b0;
      send_block(3);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("rstd_in_drain", 32'(busy), 1);
      rst   = 1'b1;
      flush = 1'b1;
      step();
      chk("rstd_in_ready", 32'(in_ready), 0);
      chk("rstd_out_valid", 32'(out_valid), 0);
      chk("rstd_out_data", 32'(out_data), 0);
      chk("rstd_busy", 32'(busy), 0);
      chk("rstd_overflow", 32'(overflow), 0);
      chk("rstd_blocks_sent", 32'(blocks_sent), 0);
      rst   = 1'b0;
      flush = 1'b0;
      #1;
      chk("rstd_release_in_ready", 32'(in_ready), 1);
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_random_blocks();
      test_overflow();
      test_backpressure();
      test_flush();
      test_rst_in_drain();
      repeat (2) step();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
